// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity, one or two stop bits, CLKS_PER_BIT clocks per bit.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     baud_cnt, baud_cnt_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_bit, parity_next;
    logic                 parity_en, parity_en_next;
    logic                 two_stop_q, two_stop_next;
    logic                 txd_next;
    logic                 bit_end;

    assign bit_end  = (baud_cnt == CNT_LAST);
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign tx_done  = bit_end && ((state == STOP2) || ((state == STOP1) && !two_stop_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            parity_en  <= 1'b0;
            two_stop_q <= 1'b0;
            txd        <= 1'b1;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_idx    <= bit_idx_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            parity_en  <= parity_en_next;
            two_stop_q <= two_stop_next;
            txd        <= txd_next;
        end
    end

    // txd_next is the line level for the state being entered, so txd and state move together.
    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_cnt;
        bit_idx_next   = bit_idx;
        shift_next     = shift_reg;
        parity_next    = parity_bit;
        parity_en_next = parity_en;
        two_stop_next  = two_stop_q;
        txd_next       = txd;

        if (state == IDLE) begin
            txd_next = 1'b1;
            if (tx_valid) begin
                shift_next     = tx_data;
                parity_next    = (^tx_data) ^ (parity_mode == 2'b10);
                parity_en_next = ^parity_mode;
                two_stop_next  = two_stop;
                baud_cnt_next  = '0;
                state_next     = START;
                txd_next       = 1'b0;
            end
        end else if (!bit_end) begin
            baud_cnt_next = baud_cnt + 1'b1;
        end else begin
            baud_cnt_next = '0;
            case (state)
                START: begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    txd_next     = shift_reg[0];
                end
                DATA: begin
                    if (bit_idx == IDX_LAST) begin
                        if (parity_en) begin
                            state_next = PARITY;
                            txd_next   = parity_bit;
                        end else begin
                            state_next = STOP1;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = shift_reg >> 1;
                        txd_next     = shift_reg[1];
                    end
                end
                PARITY: begin
                    state_next = STOP1;
                    txd_next   = 1'b1;
                end
                STOP1: begin
                    state_next = two_stop_q ? STOP2 : IDLE;
                    txd_next   = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                    txd_next   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: an 8-bit/4-clock instance and a 5-bit/1-clock instance,
// with a mid-bit sampling monitor checked against a scoreboard of expected frames.
module tb_uart_tx_param;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          clocks;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pm;
        logic       two;
        int         clocks;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] data_a;
    logic [4:0] data_b;
    logic       valid_a, valid_b;
    logic [1:0] pm_a, pm_b;
    logic       two_a, two_b;
    logic [1:0] ready_s, txd_s, busy_s, done_s;

    exp_t sb0[$];
    exp_t sb1[$];
    vec_t vecs[6];

    int tests = 0;
    int fails = 0;

    int          cyc[2];
    int          nbit[2];
    int          busy_cnt[2];
    int          done_cnt[2] = '{0, 0};
    int          gap[2];
    int          last_gap[2];
    bit          gap_ok[2];
    bit          last_gap_ok[2];
    bit          in_frame[2];
    logic [11:0] cap[2];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(rst_a), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_s[0]), .parity_mode(pm_a), .two_stop(two_a),
        .txd(txd_s[0]), .busy(busy_s[0]), .tx_done(done_s[0])
    );

    uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(rst_b), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_s[1]), .parity_mode(pm_b), .two_stop(two_b),
        .txd(txd_s[1]), .busy(busy_s[1]), .tx_done(done_s[1])
    );

    task automatic check_output(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s).
    function automatic exp_t model(input int nd, input logic [8:0] d, input logic [1:0] pm,
                                   input logic two, input int clocks);
        exp_t e;
        int   n;
        logic p;
        e.bits = '0;
        n = 1;
        p = 1'b0;
        for (int k = 0; k < nd; k++) begin
            e.bits[n] = d[k];
            p = p ^ d[k];
            n++;
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            e.bits[n] = p ^ (pm == 2'b10);
            n++;
        end
        e.bits[n] = 1'b1;
        n++;
        if (two) begin
            e.bits[n] = 1'b1;
            n++;
        end
        e.nbits  = n;
        e.clocks = clocks;
        return e;
    endfunction

    function automatic int idle_vec(input int i);
        return int'({txd_s[i], ready_s[i], busy_s[i], done_s[i]});
    endfunction

    // Drives one word, returns at the negedge of the first frame cycle with inputs scrambled.
    task automatic apply_stimulus(input int i, input logic [8:0] d, input logic [1:0] pm,
                                  input logic two, input bit push, input int clocks);
        int k;
        k = 0;
        @(negedge clk);
        while (!ready_s[i] && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_output("ready_before_send", int'(ready_s[i]), 1);
        if (i == 0) begin
            data_a = d[7:0]; pm_a = pm; two_a = two; valid_a = 1'b1;
            if (push) sb0.push_back(model(8, d, pm, two, clocks));
        end else begin
            data_b = d[4:0]; pm_b = pm; two_b = two; valid_b = 1'b1;
            if (push) sb1.push_back(model(5, d, pm, two, clocks));
        end
        @(negedge clk);
        if (i == 0) begin
            valid_a = 1'b0; data_a = ~d[7:0]; pm_a = ~pm; two_a = ~two;
        end else begin
            valid_b = 1'b0; data_b = ~d[4:0]; pm_b = ~pm; two_b = ~two;
        end
    endtask

    task automatic wait_done(input int i);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done_s[i]) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("tx_done_seen", int'(seen), 1);
    endtask

    // Monitor: frame starts when busy rises, txd sampled at mid-bit, frame ends on tx_done.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic r, b, t, d, have;
                int   cpb;
                exp_t e;
                r   = (i == 0) ? rst_a : rst_b;
                cpb = (i == 0) ? 4 : 1;
                b   = busy_s[i];
                t   = txd_s[i];
                d   = done_s[i];
                if (!r) begin
                    in_frame[i] = 1'b0;
                    gap[i]      = 0;
                    gap_ok[i]   = 1'b1;
                end else begin
                    if (!in_frame[i]) begin
                        if (d) check_output("done_outside_frame", int'(d), 0);
                        if (b) begin
                            in_frame[i]    = 1'b1;
                            cyc[i]         = 0;
                            nbit[i]        = 0;
                            cap[i]         = '0;
                            busy_cnt[i]    = 0;
                            last_gap[i]    = gap[i];
                            last_gap_ok[i] = gap_ok[i];
                        end else begin
                            gap[i]++;
                            if (t !== 1'b1) gap_ok[i] = 1'b0;
                        end
                    end
                    if (in_frame[i]) begin
                        cyc[i]++;
                        if (b) busy_cnt[i]++;
                        if (((cyc[i] - 1) % cpb) == (cpb / 2) && nbit[i] < 12) begin
                            cap[i][nbit[i]] = t;
                            nbit[i]++;
                        end
                        if (d) begin
                            have = 1'b0;
                            if (i == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
                            if (i == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
                            check_output("expected_frame_queued", int'(have), 1);
                            if (have) begin
                                check_output("frame_clocks", cyc[i], e.clocks);
                                check_output("busy_cycles", busy_cnt[i], e.clocks);
                                check_output("frame_bit_count", nbit[i], e.nbits);
                                check_output("frame_bits", int'(cap[i]), int'(e.bits));
                            end
                            done_cnt[i]++;
                            in_frame[i] = 1'b0;
                            gap[i]      = 0;
                            gap_ok[i]   = 1'b1;
                        end else if (!b) begin
                            check_output("busy_dropped_early", int'(b), 1);
                            in_frame[i] = 1'b0;
                            gap[i]      = 0;
                            gap_ok[i]   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dc;
        rst_a = 1'b0; rst_b = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0; data_b = '0;
        pm_a = 2'b00; pm_b = 2'b00;
        two_a = 1'b0; two_b = 1'b0;

        vecs = '{
            '{8'hA5, 2'b01, 1'b0, 44},
            '{8'hA5, 2'b10, 1'b0, 44},
            '{8'hA5, 2'b00, 1'b0, 40},
            '{8'hA5, 2'b11, 1'b0, 40},
            '{8'h00, 2'b00, 1'b1, 44},
            '{8'hC3, 2'b10, 1'b1, 48}
        };

        repeat (3) @(negedge clk);
        check_output("in_reset_a", idle_vec(0), 4'b1100);
        check_output("in_reset_b", idle_vec(1), 4'b1100);
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_output("idle_after_reset_a", idle_vec(0), 4'b1100);
            check_output("idle_after_reset_b", idle_vec(1), 4'b1100);
        end

        for (int k = 0; k < 6; k++) begin
            apply_stimulus(0, {1'b0, vecs[k].data}, vecs[k].pm, vecs[k].two, 1'b1, vecs[k].clocks);
            wait_done(0);
        end

        // Back-to-back with tx_valid held; tx_data changes while each frame is in flight.
        @(negedge clk);
        data_a = 8'h55; pm_a = 2'b00; two_a = 1'b0; valid_a = 1'b1;
        sb0.push_back(model(8, 9'h055, 2'b00, 1'b0, 40));
        @(negedge clk);
        data_a = 8'h3C;
        sb0.push_back(model(8, 9'h03C, 2'b00, 1'b0, 40));
        wait_done(0);
        @(negedge clk);
        check_output("b2b_gap_txd", int'(txd_s[0]), 1);
        check_output("b2b_gap_ready", int'(ready_s[0]), 1);
        @(negedge clk);
        valid_a = 1'b0;
        data_a  = 8'hFF;
        wait_done(0);
        check_output("b2b_idle_gap_clocks", last_gap[0], 1);
        check_output("b2b_idle_gap_txd_high", int'(last_gap_ok[0]), 1);

        // Abort during data bit 3 of 0xFF, then a clean frame.
        dc = done_cnt[0];
        apply_stimulus(0, 9'h0FF, 2'b00, 1'b0, 1'b0, 0);
        repeat (17) @(negedge clk);
        #1 rst_a = 1'b0;
        #1 check_output("abort_outputs_a", idle_vec(0), 4'b1100);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (5) @(negedge clk);
        check_output("abort_no_done_a", done_cnt[0], dc);
        apply_stimulus(0, 9'h081, 2'b01, 1'b0, 1'b1, 44);
        wait_done(0);

        // Same for the 5-bit, one-clock-per-bit instance.
        dc = done_cnt[1];
        apply_stimulus(1, 9'h01F, 2'b00, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        #1 rst_b = 1'b0;
        #1 check_output("abort_outputs_b", idle_vec(1), 4'b1100);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check_output("abort_no_done_b", done_cnt[1], dc);
        apply_stimulus(1, 9'h011, 2'b00, 1'b0, 1'b1, 7);
        wait_done(1);
        apply_stimulus(1, 9'h016, 2'b10, 1'b1, 1'b1, 9);
        wait_done(1);

        repeat (5) @(negedge clk);
        check_output("scoreboard_a_drained", sb0.size(), 0);
        check_output("scoreboard_b_drained", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter; the next generation of the team's fixed 8-bit, one-bit-per-clock transmitter.
- Serialises one frame per accepted word: start bit, DATA_BITS data bits LSB first, optional parity, then one or two stop bits.
- Each bit is held for CLKS_PER_BIT clocks by an internal baud counter.
- Sits between the host-side byte source (valid/ready handshake) and the TXD pad.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clocks per serial bit; legal range >= 1. A value of 1 gives one bit per clock.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately. Deassertion is synchronised externally.
tx_data  input  DATA_BITS  word to send; sampled only on accept.
tx_valid  input  1  source has a word available.
tx_ready  output  1  block can accept a word.
parity_mode  input  2  00 = none, 01 = even, 10 = odd, 11 = none. Sampled on accept.
two_stop  input  1  1 = two stop bits, 0 = one stop bit. Sampled on accept.
txd  output  1  serial line; idle level is 1.
busy  output  1  a frame is in progress.
tx_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset values: txd=1, tx_ready=1, busy=0, tx_done=0. The FSM goes to IDLE and the baud counter, bit index, shift register and latched configuration are all cleared.
- Reset asserted mid-frame aborts the frame. txd goes to 1 asynchronously. No tx_done is produced.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Accept:
  - Occurs when tx_valid && tx_ready at a rising edge.
  - tx_ready = (state==IDLE); it is a registered-state decode only and has no combinational path from tx_valid.
  - On accept, the block latches tx_data, the parity mode and two_stop.
  - Parity bit is computed on accept: even = XOR of the data bits; odd = inverted XOR.
  - The FSM enters START and the baud counter is loaded with 0.
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1. The bit ends when counter == CLKS_PER_BIT-1; at that point the counter wraps to 0 and the FSM advances.
  - Counter width is clog2(CLKS_PER_BIT), minimum 1 bit.
  - txd is a registered output. It changes on the same edge as the state.
- Transitions at bit end:
  - START -> DATA, with bit index = 0.
  - DATA: if the index is DATA_BITS-1, go to PARITY when parity is enabled, otherwise STOP1. Otherwise increment the index.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if two_stop, else IDLE.
  - STOP2 -> IDLE.
- txd per state: START=0; DATA=data[index]; PARITY=parity bit; STOP1/STOP2/IDLE=1.
- busy = (state != IDLE).
- tx_done is asserted for exactly one cycle: the last clock of the final stop bit. On the next edge the FSM is back in IDLE.
- Frame length in clocks = CLKS_PER_BIT × (1 + DATA_BITS + P + S), where P ∈ {0,1} (parity enabled) and S ∈ {1,2} (stop bits).
- Back-to-back operation:
  - A word can be accepted in the first IDLE cycle. This gives a minimum 1-clock idle gap (txd=1) between frames.
  - tx_valid held high sends continuous frames.
- Changes to tx_data, parity_mode or two_stop while busy have no effect on the current frame.
- tx_valid while busy is ignored. The source must hold it until tx_ready.

Test Plan:
1. Reset, no stimulus: txd=1, tx_ready=1, busy=0, tx_done=0 for 20 cycles.
2. Even-parity frame (DATA_BITS=8, CLKS_PER_BIT=4, 0xA5, parity_mode=01, two_stop=0):
   - Sampling at mid-bit, txd = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop).
   - busy is high for 44 cycles. tx_done pulses on cycle 44 after accept.
3. Odd parity and no parity on 0xA5:
   - parity_mode=10 gives a parity bit of 1, frame 44 clocks.
   - parity_mode=00 and 11 give no parity bit, frame 40 clocks.
4. Two stop bits on 0x00, no parity: txd is 0 for 36 clocks, then 1 for 8 clocks. tx_done is at clock 44.
5. Back-to-back: tx_valid held high with 0x55 then 0x3C. Exactly one idle clock with txd=1 between frames, and two tx_done pulses. Changing tx_data mid-frame does not alter the bits on txd.
6. Reset mid-frame:
   - Assert reset during DATA bit 3 of 0xFF: txd=1 and busy=0 immediately, no tx_done.
   - After release, a new accept of 0x81 transmits a correct frame.
   - Repeat with DATA_BITS=5 and CLKS_PER_BIT=1: a 5-bit frame with one clock per bit.
